trig_param_bank: RTL

//  Parametrised bank of trigger-loaded 32-bit simulation parameters (tau, gain, gamma_dyn/sta, BDAMP_*, ...).

---
 rtl/trig_param_bank.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/trig_param_bank.sv
// Bank of trigger-loaded parameters: host writes land in shadow registers and are committed
// atomically on commit_tick. Optional readback port enabled by defining PARAM_READBACK_EN.
module trig_param_bank #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int TRIG_W   = 16,
  parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [TRIG_W-1:0]            trig,
  input  logic [15:0]                  wire_lo,
  input  logic [15:0]                  wire_hi,
  input  logic                         commit_tick,
  input  logic                         restore,
  output logic [NUM_REGS*DATA_W-1:0]   param_flat,
  output logic [NUM_REGS-1:0]          pending,
  output logic                         busy,
  output logic                         err_drop
`ifdef PARAM_READBACK_EN
  ,input  logic [7:0]                  rd_sel
  ,input  logic                        rd_shadow
  ,output logic [31:0]                 rd_data
`endif
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [TRIG_W-1:0] VALID_MASK = TRIG_W'((64'd1 << NUM_REGS) - 64'd1);

  typedef enum logic {S_IDLE, S_RESTORE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     active_q [NUM_REGS];
  logic [DATA_W-1:0]     active_d [NUM_REGS];
  logic [DATA_W-1:0]     shadow_q [NUM_REGS];
  logic [DATA_W-1:0]     shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [NUM_REGS-1:0]   set_mask;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [31:0]           wire_data;
  logic [TRIG_W-1:0]     trig_valid;
  logic                  trig_any;
  logic                  trig_multi;

  assign wire_data  = {wire_hi, wire_lo};
  assign trig_valid = trig & VALID_MASK;
  assign trig_any   = |trig_valid;
  assign trig_multi = |(trig_valid & (trig_valid - TRIG_W'(1)));

  // Commit reads the pre-cycle shadow/pending; new stages from this cycle survive the clear.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    err_d     = err_q;
    set_mask  = '0;

    if (commit_tick) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (pending_q[k]) active_d[k] = shadow_q[k];
      end
      pending_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (trig_valid[k]) shadow_d[k] = wire_data[DATA_W-1:0];
        end
        set_mask = trig_valid[NUM_REGS-1:0];
        if (trig_multi) err_d = 1'b1;
        if (restore) begin
          state_d = S_RESTORE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RESTORE: begin
        if (trig_any) err_d = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            shadow_d[k] = DEFAULTS[k*DATA_W +: DATA_W];
            set_mask[k] = 1'b1;
          end
        end
        if (idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    pending_d = pending_d | set_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        active_q[k] <= DEFAULTS[k*DATA_W +: DATA_W];
        shadow_q[k] <= DEFAULTS[k*DATA_W +: DATA_W];
      end
      pending_q <= '0;
      state_q   <= S_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    param_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      param_flat[k*DATA_W +: DATA_W] = active_q[k];
    end
  end

  assign pending  = pending_q;
  assign busy     = busy_q;
  assign err_drop = err_q;

`ifdef PARAM_READBACK_EN
  logic [31:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_sel == 8'(k)) rd_data_d[DATA_W-1:0] = rd_shadow ? shadow_q[k] : active_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule
